axi_mem_port_arbiter: RTL and testbench

- Shares one single-port SRAM between the AXI read-only controller and the AXI write-only controller of the same slave.
- Each controller raises valid_o and drives its memory-port signals; the arbiter returns grant_i to at most one of them per cycle and muxes the granted side onto the SRAM.
- Grants are sticky for bursts, with a consecutive-grant cap to prevent starvation.
- Tracks 1-cycle SRAM read latency and flags returned read data.

---
 rtl/axi_mem_port_arbiter_if.sv | 31 +++
 rtl/axi_mem_port_arbiter.sv | 51 +++++
 tb/tb_axi_mem_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_port_arbiter_if.sv
// axi_mem_port_arbiter_if: read-side, write-side and SRAM-side signals of the shared memory port.
interface axi_mem_port_arbiter_if #(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH/8
);
  logic                      RD_valid_i, RD_grant_o, RD_CEN_i, RD_WEN_i, RD_Q_valid_o;
  logic [MEM_ADDR_WIDTH-1:0] RD_A_i;
  logic [DATA_WIDTH-1:0]     RD_D_i, RD_Q_o;
  logic [BE_WIDTH-1:0]       RD_BE_i;
  logic                      WR_valid_i, WR_grant_o, WR_CEN_i, WR_WEN_i;
  logic [MEM_ADDR_WIDTH-1:0] WR_A_i;
  logic [DATA_WIDTH-1:0]     WR_D_i;
  logic [BE_WIDTH-1:0]       WR_BE_i;
  logic                      MEM_CEN_o, MEM_WEN_o;
  logic [MEM_ADDR_WIDTH-1:0] MEM_A_o;
  logic [DATA_WIDTH-1:0]     MEM_D_o, MEM_Q_i;
  logic [BE_WIDTH-1:0]       MEM_BE_o;
  modport slave (
    input  RD_valid_i, RD_CEN_i, RD_WEN_i, RD_A_i, RD_D_i, RD_BE_i,
    input  WR_valid_i, WR_CEN_i, WR_WEN_i, WR_A_i, WR_D_i, WR_BE_i, MEM_Q_i,
    output RD_grant_o, RD_Q_o, RD_Q_valid_o, WR_grant_o,
    output MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
  );
  modport master (
    output RD_valid_i, RD_CEN_i, RD_WEN_i, RD_A_i, RD_D_i, RD_BE_i,
    output WR_valid_i, WR_CEN_i, WR_WEN_i, WR_A_i, WR_D_i, WR_BE_i, MEM_Q_i,
    input  RD_grant_o, RD_Q_o, RD_Q_valid_o, WR_grant_o,
    input  MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
  );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// axi_mem_port_arbiter: shares one single-port SRAM between read and write controllers.
module axi_mem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int MAX_CONSEC     = 4
) (
  input logic clk,
  input logic rst_n,
  axi_mem_port_arbiter_if.slave bus
);
  typedef enum logic {OWN_RD, OWN_WR} owner_e;
  localparam logic [7:0] MAXC = 8'(MAX_CONSEC);
  owner_e     owner_q, owner_d;
  logic [7:0] run_q, run_d;
  logic       rd_pend_q, rd_pend_d;
  logic       both, gnt_rd, gnt_wr, granted;
  assign both    = bus.RD_valid_i & bus.WR_valid_i;
  // Under contention the owner keeps the port until its run reaches the cap.
  assign gnt_rd  = both ? ((run_q < MAXC) == (owner_q == OWN_RD)) : bus.RD_valid_i;
  assign gnt_wr  = both ? ~gnt_rd : bus.WR_valid_i;
  assign granted = gnt_rd | gnt_wr;
  assign bus.RD_grant_o   = gnt_rd;
  assign bus.WR_grant_o   = gnt_wr;
  assign bus.MEM_CEN_o    = gnt_rd ? bus.RD_CEN_i : gnt_wr ? bus.WR_CEN_i : 1'b1;
  assign bus.MEM_WEN_o    = gnt_rd ? bus.RD_WEN_i : gnt_wr ? bus.WR_WEN_i : 1'b1;
  assign bus.MEM_A_o      = gnt_rd ? bus.RD_A_i   : gnt_wr ? bus.WR_A_i   : '0;
  assign bus.MEM_D_o      = gnt_rd ? bus.RD_D_i   : gnt_wr ? bus.WR_D_i   : '0;
  assign bus.MEM_BE_o     = gnt_rd ? bus.RD_BE_i  : gnt_wr ? bus.WR_BE_i  : '0;
  assign bus.RD_Q_o       = bus.MEM_Q_i;
  assign bus.RD_Q_valid_o = rd_pend_q;
  always_comb begin
    owner_d   = owner_q;
    run_d     = 8'd0;
    rd_pend_d = granted & ~bus.MEM_CEN_o & bus.MEM_WEN_o;
    if (granted) begin
      owner_d = gnt_wr ? OWN_WR : OWN_RD;
      run_d   = (owner_d != owner_q) ? 8'd1 : (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_q   <= OWN_RD;
      run_q     <= 8'd0;
      rd_pend_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      run_q     <= run_d;
      rd_pend_q <= rd_pend_d;
    end
endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// tb_axi_mem_port_arbiter: directed scenarios with hand-computed expectations.
module tb_axi_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  axi_mem_port_arbiter_if #(.MEM_ADDR_WIDTH(13), .DATA_WIDTH(64), .BE_WIDTH(8)) bus();
  axi_mem_port_arbiter #(.MEM_ADDR_WIDTH(13), .DATA_WIDTH(64), .BE_WIDTH(8), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic set_idle();
    bus.RD_valid_i = 0; bus.RD_CEN_i = 1; bus.RD_WEN_i = 1; bus.RD_A_i = '0;
    bus.RD_D_i = '0; bus.RD_BE_i = '0;
    bus.WR_valid_i = 0; bus.WR_CEN_i = 1; bus.WR_WEN_i = 1; bus.WR_A_i = '0;
    bus.WR_D_i = '0; bus.WR_BE_i = '0; bus.MEM_Q_i = '0;
  endtask

  task automatic set_rd(input logic v, input logic [12:0] a);
    bus.RD_valid_i = v; bus.RD_CEN_i = 0; bus.RD_WEN_i = 1; bus.RD_A_i = a; bus.RD_BE_i = 8'hFF;
  endtask

  task automatic set_wr(input logic v, input logic [12:0] a);
    bus.WR_valid_i = v; bus.WR_CEN_i = 0; bus.WR_WEN_i = 0; bus.WR_A_i = a;
    bus.WR_D_i = {51'd0, a}; bus.WR_BE_i = 8'h0F;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_idle();
    rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic check_grant(input string name, input logic er, input logic ew);
    n_checks++;
    if (bus.RD_grant_o !== er || bus.WR_grant_o !== ew) begin
      n_fail++;
      $display("FAIL %s t=%0t: grants rd=%b wr=%b, expected rd=%b wr=%b",
               name, $time, bus.RD_grant_o, bus.WR_grant_o, er, ew);
    end
  endtask

  task automatic test_reset();
    set_idle();
    #2;
    check_grant("reset_grants", 0, 0);
    n_checks++;
    if (bus.MEM_CEN_o !== 1'b1 || bus.MEM_WEN_o !== 1'b1 || bus.RD_Q_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cen=%b wen=%b qv=%b, expected 1 1 0",
               bus.MEM_CEN_o, bus.MEM_WEN_o, bus.RD_Q_valid_o);
    end
    n_checks++;
    if (bus.MEM_A_o !== 13'd0 || bus.MEM_D_o !== 64'd0 || bus.MEM_BE_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_bus: a=%h d=%h be=%h, expected zeros", bus.MEM_A_o, bus.MEM_D_o, bus.MEM_BE_o);
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_write_only();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_idle();
      set_wr(1, 13'(16 + i));
      @(negedge clk);
      check_grant("wr_only_grant", 0, 1);
      n_checks++;
      if (bus.MEM_A_o !== 13'(16 + i) || bus.MEM_WEN_o !== 1'b0 || bus.MEM_D_o !== 64'(16 + i)
          || bus.MEM_BE_o !== 8'h0F || bus.RD_Q_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_only_bus[%0d]: a=%h wen=%b d=%h be=%h qv=%b, expected a=%h wen=0 be=0f qv=0",
                 i, bus.MEM_A_o, bus.MEM_WEN_o, bus.MEM_D_o, bus.MEM_BE_o, bus.RD_Q_valid_o, 13'(16 + i));
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check_grant("idle_grant", 0, 0);
    n_checks++;
    if (bus.MEM_CEN_o !== 1'b1 || bus.MEM_A_o !== 13'd0 || bus.RD_Q_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bus: cen=%b a=%h qv=%b, expected 1 0 0", bus.MEM_CEN_o, bus.MEM_A_o, bus.RD_Q_valid_o);
    end
  endtask

  task automatic run_contention(input string name, input int n, input logic [11:0] seq);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_rd(1, 13'(256 + i));
      set_wr(1, 13'(512 + i));
      @(negedge clk);
      check_grant(name, seq[i], ~seq[i]);
      n_checks++;
      if (bus.MEM_A_o !== (seq[i] ? 13'(256 + i) : 13'(512 + i))) begin
        n_fail++;
        $display("FAIL %s_addr[%0d]: a=%h, expected %h", name, i, bus.MEM_A_o,
                 seq[i] ? 13'(256 + i) : 13'(512 + i));
      end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_contention();
    do_reset();
    run_contention("contention", 12, 12'b1111_0000_1111);
  endtask

  task automatic test_read_return();
    @(posedge clk); #1;
    set_idle();
    set_rd(1, 13'h1A5);
    @(negedge clk);
    check_grant("read_grant", 1, 0);
    n_checks++;
    if (bus.MEM_A_o !== 13'h1A5 || bus.MEM_CEN_o !== 1'b0 || bus.MEM_WEN_o !== 1'b1 || bus.RD_Q_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_issue: a=%h cen=%b wen=%b qv=%b, expected 1a5 0 1 0",
               bus.MEM_A_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.RD_Q_valid_o);
    end
    @(posedge clk); #1;
    set_idle();
    bus.MEM_Q_i = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    n_checks++;
    if (bus.RD_Q_valid_o !== 1'b1 || bus.RD_Q_o !== 64'hDEADBEEF_CAFEF00D) begin
      n_fail++;
      $display("FAIL read_data: qv=%b q=%h, expected 1 deadbeefcafef00d", bus.RD_Q_valid_o, bus.RD_Q_o);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (bus.RD_Q_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_valid_drop: qv=%b, expected 0", bus.RD_Q_valid_o);
    end
  endtask

  task automatic test_idle_clears_run();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_idle();
      set_wr(1, 13'(32 + i));
      @(negedge clk);
      check_grant("wr_hold", 0, 1);
    end
    @(posedge clk); #1;
    set_idle();
    run_contention("after_idle", 5, 12'b0000_0001_0000);
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    set_idle();
    set_rd(1, 13'h0AA);
    @(negedge clk);
    check_grant("pre_reset_read", 1, 0);
    @(posedge clk); #1;
    set_idle();
    rst_n = 0;
    #1;
    n_checks++;
    if (bus.RD_Q_valid_o !== 1'b0 || bus.MEM_CEN_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drop: qv=%b cen=%b, expected 0 1", bus.RD_Q_valid_o, bus.MEM_CEN_o);
    end
    @(negedge clk) rst_n = 1;
    run_contention("post_reset", 5, 12'b0000_0000_1111);
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_contention();
    test_read_return();
    test_idle_clears_run();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    n_checks++;
    if (bus.RD_grant_o === 1'b1 && bus.WR_grant_o === 1'b1) begin
      n_fail++;
      $display("FAIL both_grants t=%0t: rd=1 wr=1, expected at most one", $time);
    end
  end
endmodule
